// File: rtl/sel_dispatch_pkg.sv
// Shared types and helpers for the selector dispatch controller.
package sel_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    DRIVE     = 2'd2,
    WAIT_FREE = 2'd3
  } sel_dispatch_state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 255;

  // Destination index width; a two-port selector still needs one bit.
  function automatic int idxWidth(input int numPorts);
    return (numPorts <= 2) ? 1 : $clog2(numPorts);
  endfunction

endpackage

// File: rtl/sel_dispatch_fifo.sv
// Synchronous job FIFO; full/empty/count derive from the registered count only.
module sel_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             doPush, doPop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];
  // A pop in the same cycle never makes room for a push when full.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/sel_dispatch_ctrl.sv
// Dispatch controller: queues destination jobs, drives a one-hot select, one drive
// pulse per job, holds select until free. Optional watchdog: SEL_DISPATCH_TIMEOUT_EN.
module sel_dispatch_ctrl
  import sel_dispatch_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int IDX_W       = idxWidth(NUM_PORTS),
  parameter int FIFO_DEPTH  = 4,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [IDX_W-1:0]     i_req_dest,
  output logic [NUM_PORTS-1:0] o_select,
  output logic                 o_drive,
  input  logic                 i_free,
  output logic                 o_busy,
  output logic [15:0]          o_issued,
  output logic                 o_err
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || FIFO_DEPTH < 2 ||
      SETUP_CYC < 0 || SETUP_CYC > 15 || TIMEOUT_CYC < 1) begin : gParamCheck
    $error("sel_dispatch_ctrl: parameter out of range");
  end

  sel_dispatch_state_t state, nextState;
  logic [IDX_W-1:0]            headDest;
  logic                        fifoFull, fifoEmpty, fifoPop;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic [3:0]                  setupCnt;
  logic                        badDest, timeoutHit;

  function automatic logic [NUM_PORTS-1:0] selDecode(input logic [IDX_W-1:0] d);
    logic [NUM_PORTS-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (d == IDX_W'(i)) s[i] = 1'b1;
    return s;
  endfunction

  sel_dispatch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(IDX_W)) uFifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (i_req_valid),
    .pop    (fifoPop),
    .wrData (i_req_dest),
    .rdData (headDest),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  assign o_req_ready = !fifoFull;
  assign o_busy      = (state != IDLE) || (fifoCount != '0);
  assign badDest     = int'(headDest) >= NUM_PORTS;

`ifdef SEL_DISPATCH_TIMEOUT_EN
  logic [15:0] waitCnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  waitCnt <= '0;
    else if (state != WAIT_FREE) waitCnt <= '0;
    else                        waitCnt <= waitCnt + 16'd1;
  end

  assign timeoutHit = (state == WAIT_FREE) && !i_free &&
                      (waitCnt == 16'(TIMEOUT_CYC - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    nextState = state;
    fifoPop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          if (!badDest) nextState = SETUP;
        end
      end
      SETUP:     if (setupCnt <= 4'd1) nextState = DRIVE;
      DRIVE:     nextState = WAIT_FREE;
      WAIT_FREE: if (i_free || timeoutHit) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      o_select <= '0;
      o_drive  <= 1'b0;
      o_issued <= '0;
      o_err    <= 1'b0;
      setupCnt <= '0;
    end else begin
      state   <= nextState;
      o_drive <= (nextState == DRIVE);
      if (state == DRIVE) o_issued <= o_issued + 16'd1;
      if (fifoPop) begin
        if (badDest) begin
          o_err <= 1'b1;
        end else begin
          o_select <= selDecode(headDest);
          setupCnt <= 4'(SETUP_CYC);
        end
      end else if (state == SETUP && setupCnt > 4'd1) begin
        setupCnt <= setupCnt - 4'd1;
      end
      // Select is released on free or watchdog expiry, never earlier.
      if (state == WAIT_FREE && nextState == IDLE) o_select <= '0;
      if (timeoutHit) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sel_dispatch_ctrl.sv
// Directed bench for sel_dispatch_ctrl with a drive-order scoreboard.
module tb_sel_dispatch_ctrl;
  localparam int NP = 3, DEPTH = 4, SETUP = 1, TMO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req_valid, o_req_ready, o_drive, i_free, o_busy, o_err;
  logic [1:0]    i_req_dest;
  logic [NP-1:0] o_select;
  logic [15:0]   o_issued;

  int checks = 0, errors = 0;
  logic [NP-1:0] expSel[$];

  sel_dispatch_ctrl #(
    .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_dest(i_req_dest), .o_select(o_select), .o_drive(o_drive), .i_free(i_free),
    .o_busy(o_busy), .o_issued(o_issued), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every drive pulse must match the oldest outstanding valid job.
  always @(negedge clk) begin
    if (rstn === 1'b1 && o_drive === 1'b1) begin
      checks++;
      assert (expSel.size() != 0) else begin
        errors++;
        $error("FAIL unexpectedDrive: observed drive with select %0h expected no drive", o_select);
      end
      if (expSel.size() != 0) check("driveSel", 32'(o_select), 32'(expSel.pop_front()));
    end
  end

  task automatic push(input logic [1:0] d, input bit good);
    int n = 0;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_dest  = d;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pushAccepted", 32'(n < 50), 32'd1);
    if (good) expSel.push_back(NP'(1) << d);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic waitDrive(input string tag);
    int n = 0;
    @(negedge clk);
    while (o_drive !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 40), 32'd1);
  endtask

  task automatic pulseFree();
    @(negedge clk) i_free = 1'b1;
    @(negedge clk) i_free = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; i_req_valid = 1'b0; i_req_dest = '0; i_free = 1'b0;
    repeat (2) @(negedge clk);
    check("rstSelect", 32'(o_select), 0);
    check("rstDrive",  32'(o_drive), 0);
    check("rstIssued", 32'(o_issued), 0);
    check("rstErr",    32'(o_err), 0);
    check("rstBusy",   32'(o_busy), 0);
    check("rstReady",  32'(o_req_ready), 1);
    rstn = 1'b1;

    // Single job, exact latency and free release
    @(negedge clk);
    i_req_valid = 1'b1; i_req_dest = 2'd1; expSel.push_back(3'b010);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("t1PopSel", 32'(o_select), 0);
    check("t1Busy",   32'(o_busy), 1);
    @(negedge clk);
    check("t1SetupSel",   32'(o_select), 32'b010);
    check("t1SetupDrive", 32'(o_drive), 0);
    @(negedge clk);
    check("t1Drive", 32'(o_drive), 1);
    @(negedge clk);
    check("t1DriveOnce", 32'(o_drive), 0);
    @(negedge clk);
    @(negedge clk);
    check("t1HeldSel", 32'(o_select), 32'b010);
    i_free = 1'b1;
    @(negedge clk);
    i_free = 1'b0;
    check("t1FreedSel", 32'(o_select), 0);
    check("t1Issued",   32'(o_issued), 1);
    check("t1IdleBusy", 32'(o_busy), 0);

    // Backpressure: blocker held in WAIT_FREE, then five queued jobs
    push(2'd2, 1'b1);
    waitDrive("t2BlockDrive");
    for (int i = 0; i < 4; i++) push(2'(i % 2), 1'b1);
    @(negedge clk);
    check("t2FullReady", 32'(o_req_ready), 0);
    i_req_valid = 1'b1; i_req_dest = 2'd0;
    @(negedge clk);
    check("t2StillFull", 32'(o_req_ready), 0);
    i_free = 1'b1;
    @(negedge clk);
    i_free = 1'b0;
    check("t2NoPassThru", 32'(o_req_ready), 0);
    begin
      int n = 0;
      while (!o_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t2FifthAccepted", 32'(n < 20), 1);
    end
    expSel.push_back(3'b001);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      waitDrive("t2JobDrive");
      pulseFree();
    end
    @(negedge clk);
    check("t2Issued",  32'(o_issued), 7);
    check("t2Drained", 32'(expSel.size()), 0);

    // Free pulses in IDLE and on the DRIVE cycle are ignored
    pulseFree();
    check("t4IdleBusy", 32'(o_busy), 0);
    push(2'd0, 1'b1);
    waitDrive("t4Drive");
    i_free = 1'b1;
    @(negedge clk);
    i_free = 1'b0;
    check("t4WaitSel",  32'(o_select), 32'b001);
    check("t4WaitBusy", 32'(o_busy), 1);
    repeat (2) @(negedge clk);
    check("t4StillSel", 32'(o_select), 32'b001);
    pulseFree();
    check("t4FreedSel", 32'(o_select), 0);

    // No free after drive: watchdog when enabled, otherwise indefinite wait
    push(2'd1, 1'b1);
    waitDrive("t5Drive");
    repeat (12) @(negedge clk);
`ifdef SEL_DISPATCH_TIMEOUT_EN
    check("t5TmoErr",  32'(o_err), 1);
    check("t5TmoSel",  32'(o_select), 0);
    check("t5TmoBusy", 32'(o_busy), 0);
`else
    check("t5WaitErr",  32'(o_err), 0);
    check("t5WaitSel",  32'(o_select), 32'b010);
    check("t5WaitBusy", 32'(o_busy), 1);
    pulseFree();
`endif
    push(2'd0, 1'b1);
    waitDrive("t5NextDrive");
    pulseFree();
    check("t5Issued", 32'(o_issued), 10);

    // Asynchronous reset in WAIT_FREE with two jobs queued
    push(2'd1, 1'b1);
    waitDrive("t6Drive");
    push(2'd0, 1'b1);
    push(2'd2, 1'b1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6RstSelect", 32'(o_select), 0);
    check("t6RstDrive",  32'(o_drive), 0);
    check("t6RstIssued", 32'(o_issued), 0);
    check("t6RstErr",    32'(o_err), 0);
    check("t6RstBusy",   32'(o_busy), 0);
    check("t6RstReady",  32'(o_req_ready), 1);
    expSel.delete();
    @(negedge clk) rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("t6NoDriveIssued", 32'(o_issued), 0);
    check("t6IdleBusy",      32'(o_busy), 0);

    // Out-of-range destination is discarded and flagged
    check("t3ErrBefore", 32'(o_err), 0);
    push(2'd3, 1'b0);
    push(2'd2, 1'b1);
    waitDrive("t3Drive");
    check("t3Err", 32'(o_err), 1);
    pulseFree();
    check("t3Issued", 32'(o_issued), 1);
    check("t3Drained", 32'(expSel.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
